control_pipe: RTL and testbench

- Pipelined control unit for the 5-stage MIPS datapath; parametrised successor to the single-cycle control decoder.
- Decodes the opcode in ID and carries the control bundle through the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Detects load-use hazards and generates stall, bubble and flush behaviour.
- Records unimplemented opcodes in a sticky error flag instead of driving x.

---
 rtl/control_pipe.sv | 188 ++++++++++++++++++
 tb/tb_control_pipe.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/control_pipe.sv
// control_pipe: pipelined MIPS control unit (ID decode, ID/EX, EX/MEM, MEM/WB) with hazard stall, flush and sticky illegal-opcode flag.
// Optional feature macro CONTROL_PIPE_FORWARD_EN: adds forward_a/forward_b and limits the interlock to load-use.
module control_pipe #(
    parameter int REG_W         = 5,
    parameter bit ZERO_REG_SAFE = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [5:0]       opcode_id,
    input  logic [REG_W-1:0] rs_id,
    input  logic [REG_W-1:0] rt_id,
    input  logic [REG_W-1:0] rd_id,
    input  logic             flush,
    output logic             stall,
    output logic             ex_alusrc,
    output logic             ex_regdst,
    output logic [1:0]       ex_aluop,
    output logic             ex_branch,
    output logic             ex_branchne,
    output logic             ex_jump,
    output logic             mem_memread,
    output logic             mem_memwrite,
    output logic             mem_branch,
    output logic             mem_branchne,
    output logic             mem_jump,
    output logic             wb_regwrite,
    output logic             wb_memtoreg,
    output logic [REG_W-1:0] ex_rs,
    output logic [REG_W-1:0] ex_rt,
    output logic [REG_W-1:0] mem_wreg,
    output logic [REG_W-1:0] wb_wreg,
`ifdef CONTROL_PIPE_FORWARD_EN
    output logic [1:0]       forward_a,
    output logic [1:0]       forward_b,
`endif
    output logic             illegal_op
);
    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_BNE  = 6'd5;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_ADDI = 6'd8;

    typedef struct packed {
        logic       alusrc;
        logic       regdst;
        logic [1:0] aluop;
        logic       branch;
        logic       branchne;
        logic       jump;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        logic       memtoreg;
    } ctrl_t;

    typedef struct packed {
        ctrl_t            ctrl;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic             memread;
        logic             memwrite;
        logic             branch;
        logic             branchne;
        logic             jump;
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] wreg;
    } mem_t;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic [REG_W-1:0] wreg;
    } wb_t;

    ctrl_t            id_ctrl;
    logic             id_legal;
    ex_t              ex_q, ex_d;
    mem_t             mem_q, mem_d;
    wb_t              wb_q, wb_d;
    logic             illegal_q, illegal_d;
    logic [REG_W-1:0] ex_wreg;
    logic             load_use;

    // Register 0 is hardwired, so with ZERO_REG_SAFE it never produces a dependency.
    function automatic logic hit(input logic [REG_W-1:0] dst, input logic [REG_W-1:0] src);
        return dst == src && (!ZERO_REG_SAFE || dst != '0);
    endfunction

    always_comb begin
        id_ctrl  = '0;
        id_legal = 1'b1;
        case (opcode_id)
            OP_R: begin
                id_ctrl.regdst   = 1'b1;
                id_ctrl.regwrite = 1'b1;
                id_ctrl.aluop    = 2'b10;
            end
            OP_LW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memtoreg = 1'b1;
                id_ctrl.regwrite = 1'b1;
                id_ctrl.memread  = 1'b1;
            end
            OP_SW: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.memwrite = 1'b1;
            end
            OP_BEQ: begin
                id_ctrl.branch = 1'b1;
                id_ctrl.aluop  = 2'b01;
            end
            OP_BNE: begin
                id_ctrl.branchne = 1'b1;
                id_ctrl.aluop    = 2'b01;
            end
            OP_J:    id_ctrl.jump = 1'b1;
            OP_ADDI: begin
                id_ctrl.alusrc   = 1'b1;
                id_ctrl.regwrite = 1'b1;
            end
            default: id_legal = 1'b0;
        endcase
    end

    assign ex_wreg  = ex_q.ctrl.regdst ? ex_q.rd : ex_q.rt;
    assign load_use = ex_q.ctrl.memread && (hit(ex_q.rt, rs_id) || hit(ex_q.rt, rt_id));

`ifdef CONTROL_PIPE_FORWARD_EN
    assign stall     = !flush && load_use;
    assign forward_a = (mem_q.regwrite && hit(mem_q.wreg, ex_q.rs)) ? 2'b10 :
                       (wb_q.regwrite && hit(wb_q.wreg, ex_q.rs)) ? 2'b01 : 2'b00;
    assign forward_b = (mem_q.regwrite && hit(mem_q.wreg, ex_q.rt)) ? 2'b10 :
                       (wb_q.regwrite && hit(wb_q.wreg, ex_q.rt)) ? 2'b01 : 2'b00;
`else
    logic raw_ex, raw_mem;
    // Without forwarding, any RAW on a pending write in EX or EX/MEM must wait; MEM/WB is covered by the register file.
    assign raw_ex  = ex_q.ctrl.regwrite && (hit(ex_wreg, rs_id) || hit(ex_wreg, rt_id));
    assign raw_mem = mem_q.regwrite && (hit(mem_q.wreg, rs_id) || hit(mem_q.wreg, rt_id));
    assign stall   = !flush && (load_use || raw_ex || raw_mem);
`endif

    assign ex_d      = (stall || flush || !id_legal) ? '0 : {id_ctrl, rs_id, rt_id, rd_id};
    assign mem_d     = flush ? '0 : {ex_q.ctrl.memread, ex_q.ctrl.memwrite, ex_q.ctrl.branch, ex_q.ctrl.branchne,
                                     ex_q.ctrl.jump, ex_q.ctrl.regwrite, ex_q.ctrl.memtoreg, ex_wreg};
    assign wb_d      = {mem_q.regwrite, mem_q.memtoreg, mem_q.wreg};
    assign illegal_d = illegal_q || !id_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            ex_q      <= ex_d;
            mem_q     <= mem_d;
            wb_q      <= wb_d;
            illegal_q <= illegal_d;
        end
    end

    assign ex_alusrc    = ex_q.ctrl.alusrc;
    assign ex_regdst    = ex_q.ctrl.regdst;
    assign ex_aluop     = ex_q.ctrl.aluop;
    assign ex_branch    = ex_q.ctrl.branch;
    assign ex_branchne  = ex_q.ctrl.branchne;
    assign ex_jump      = ex_q.ctrl.jump;
    assign ex_rs        = ex_q.rs;
    assign ex_rt        = ex_q.rt;
    assign mem_memread  = mem_q.memread;
    assign mem_memwrite = mem_q.memwrite;
    assign mem_branch   = mem_q.branch;
    assign mem_branchne = mem_q.branchne;
    assign mem_jump     = mem_q.jump;
    assign mem_wreg     = mem_q.wreg;
    assign wb_regwrite  = wb_q.regwrite;
    assign wb_memtoreg  = wb_q.memtoreg;
    assign wb_wreg      = wb_q.wreg;
    assign illegal_op   = illegal_q;
endmodule

// File: tb/tb_control_pipe.sv
// tb_control_pipe: randomized + directed stimulus for control_pipe, checked by an instruction-level pipeline model via a scoreboard.
module tb_control_pipe;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [5:0]    opcode_id = '0;
    logic [RW-1:0] rs_id = '0, rt_id = '0, rd_id = '0;
    logic          flush = 1'b0;
    logic          stall, ex_alusrc, ex_regdst, ex_branch, ex_branchne, ex_jump;
    logic [1:0]    ex_aluop;
    logic          mem_memread, mem_memwrite, mem_branch, mem_branchne, mem_jump;
    logic          wb_regwrite, wb_memtoreg, illegal_op;
    logic [RW-1:0] ex_rs, ex_rt, mem_wreg, wb_wreg;
    logic [1:0]    fa, fb;

    control_pipe #(.REG_W(RW), .ZERO_REG_SAFE(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .opcode_id(opcode_id), .rs_id(rs_id), .rt_id(rt_id), .rd_id(rd_id),
        .flush(flush), .stall(stall), .ex_alusrc(ex_alusrc), .ex_regdst(ex_regdst), .ex_aluop(ex_aluop),
        .ex_branch(ex_branch), .ex_branchne(ex_branchne), .ex_jump(ex_jump), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_branch(mem_branch), .mem_branchne(mem_branchne), .mem_jump(mem_jump),
        .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .mem_wreg(mem_wreg), .wb_wreg(wb_wreg),
`ifdef CONTROL_PIPE_FORWARD_EN
        .forward_a(fa), .forward_b(fb),
`endif
        .illegal_op(illegal_op)
    );
`ifndef CONTROL_PIPE_FORWARD_EN
    assign fa = 2'b00;
    assign fb = 2'b00;
`endif

    always #5 clk = ~clk;

    // Instruction-level model: each stage holds the instruction occupying it (all-zero = bubble).
    typedef struct packed {
        logic          v;
        logic [5:0]    op;
        logic [RW-1:0] rs, rt, rd;
    } ins_t;
    typedef struct packed {
        logic       alusrc, regdst;
        logic [1:0] aluop;
        logic       br, bne, j, mr, mw, rw, m2r;
    } ctl_t;

    ins_t           s_ex = '0, s_mem = '0, s_wb = '0;
    logic           m_ill = 1'b0;
    logic [39:0]    sb[$];
    int             vectors = 0, miscompares = 0, cyc = 0;

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8};
    endfunction

    function automatic ctl_t ctl(input ins_t s);
        ctl_t c = '0;
        if (s.v)
            case (s.op)
                6'd0:  begin c.regdst = 1; c.rw = 1; c.aluop = 2'b10; end
                6'd35: begin c.alusrc = 1; c.m2r = 1; c.rw = 1; c.mr = 1; end
                6'd43: begin c.alusrc = 1; c.mw = 1; end
                6'd4:  begin c.br = 1; c.aluop = 2'b01; end
                6'd5:  begin c.bne = 1; c.aluop = 2'b01; end
                6'd2:  c.j = 1;
                6'd8:  begin c.alusrc = 1; c.rw = 1; end
                default: c = '0;
            endcase
        return c;
    endfunction

    function automatic logic [RW-1:0] dest(input ins_t s);
        return ctl(s).regdst ? s.rd : s.rt;
    endfunction

    function automatic logic reads(input ins_t id, input logic [RW-1:0] r);
        return r != '0 && (id.rs == r || id.rt == r);
    endfunction

    function automatic logic m_stall(input ins_t id, input logic fl);
        logic lu, raw;
        lu = ctl(s_ex).mr && reads(id, dest(s_ex));
`ifdef CONTROL_PIPE_FORWARD_EN
        raw = 1'b0;
`else
        raw = (ctl(s_ex).rw && reads(id, dest(s_ex))) || (ctl(s_mem).rw && reads(id, dest(s_mem)));
`endif
        return !fl && (lu || raw);
    endfunction

`ifdef CONTROL_PIPE_FORWARD_EN
    function automatic logic [1:0] fwd(input logic [RW-1:0] r);
        if (r != '0 && ctl(s_mem).rw && dest(s_mem) == r) return 2'b10;
        if (r != '0 && ctl(s_wb).rw && dest(s_wb) == r) return 2'b01;
        return 2'b00;
    endfunction
`endif

    function automatic logic [39:0] exp_vec(input logic st);
        ctl_t e = ctl(s_ex), m = ctl(s_mem), w = ctl(s_wb);
        logic [1:0] xa = 2'b00, xb = 2'b00;
`ifdef CONTROL_PIPE_FORWARD_EN
        xa = fwd(s_ex.rs);
        xb = fwd(s_ex.rt);
`endif
        return {st, e.alusrc, e.regdst, e.aluop, e.br, e.bne, e.j, m.mr, m.mw, m.br, m.bne, m.j,
                w.rw, w.m2r, s_ex.rs, s_ex.rt, dest(s_mem), dest(s_wb), m_ill, xa, xb};
    endfunction

    // One clock of stimulus: drive ID, push the expectation for this cycle, then advance the model.
    task automatic tick(input logic [5:0] op, input logic [RW-1:0] rs, rt, rd, input logic fl, output logic st);
        ins_t id;
        id = '{v: 1'b1, op: op, rs: rs, rt: rt, rd: rd};
        opcode_id = op; rs_id = rs; rt_id = rt; rd_id = rd; flush = fl;
        st = m_stall(id, fl);
        sb.push_back(exp_vec(st));
        m_ill = m_ill || !legal(op);
        s_wb  = s_mem;
        s_mem = fl ? '0 : s_ex;
        s_ex  = (fl || st || !legal(op)) ? '0 : id;
        @(posedge clk); #1;
    endtask

    // A stalled instruction stays in ID (PC and IF/ID held) until it is accepted.
    task automatic issue(input logic [5:0] op, input logic [RW-1:0] rs, rt, rd, input logic fl);
        logic st;
        do tick(op, rs, rt, rd, fl, st); while (st);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) issue(6'd0, '0, '0, '0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        s_ex = '0; s_mem = '0; s_wb = '0; m_ill = 1'b0;
        sb.push_back(exp_vec(1'b0));
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    logic [39:0] act;
    assign act = {stall, ex_alusrc, ex_regdst, ex_aluop, ex_branch, ex_branchne, ex_jump, mem_memread,
                  mem_memwrite, mem_branch, mem_branchne, mem_jump, wb_regwrite, wb_memtoreg,
                  ex_rs, ex_rt, mem_wreg, wb_wreg, illegal_op, fa, fb};

    always @(negedge clk) begin
        cyc++;
        if (sb.size() > 0) begin
            logic [39:0] e;
            e = sb.pop_front();
            vectors++;
            if (act !== e) begin
                miscompares++;
                $display("FAIL cycle %0d: got %h expected %h", cyc, act, e);
            end
        end
    end

    initial begin
        logic [5:0] ops[7] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd8};
        logic [5:0] bad[3] = '{6'd63, 6'd1, 6'd9};
        logic [5:0] op;
        int r;
        @(posedge clk); #1;
        do_reset();
        // addi then nops
        issue(6'd8, 5'd1, 5'd2, 5'd0, 1'b0);
        nops(3);
        // load-use on rt=5
        issue(6'd35, 5'd1, 5'd5, 5'd0, 1'b0);
        issue(6'd0, 5'd5, 5'd6, 5'd7, 1'b0);
        nops(3);
        // load to $0 never stalls
        issue(6'd35, 5'd1, 5'd0, 5'd0, 1'b0);
        issue(6'd0, 5'd0, 5'd0, 5'd8, 1'b0);
        nops(3);
        // flush while a load-use is pending in ID
        issue(6'd4, 5'd1, 5'd2, 5'd0, 1'b0);
        issue(6'd35, 5'd1, 5'd9, 5'd0, 1'b0);
        issue(6'd0, 5'd9, 5'd10, 5'd11, 1'b1);
        nops(3);
        // illegal opcode is sticky until reset
        issue(6'd63, 5'd1, 5'd2, 5'd3, 1'b0);
        for (int i = 0; i < 10; i++) issue(ops[i % 7], 5'(i + 1), 5'(i + 2), 5'(i + 3), 1'b0);
        do_reset();
        nops(2);
        // back-to-back and one-apart RAW on $3
        issue(6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        issue(6'd0, 5'd3, 5'd4, 5'd5, 1'b0);
        nops(3);
        issue(6'd0, 5'd1, 5'd2, 5'd3, 1'b0);
        nops(1);
        issue(6'd0, 5'd3, 5'd4, 5'd5, 1'b0);
        nops(3);
        for (int n = 0; n < 800; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 1) do_reset();
            else begin
                op = (r < 3) ? bad[$urandom_range(0, 2)] : ops[$urandom_range(0, 6)];
                issue(op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom_range(0, 7) == 0);
            end
        end
        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
